// File: rtl/btn_pkg.sv
// Shared definitions for the debounced round-robin button arbiter:
// button count, FSM state encoding and index helpers.
package btn_pkg;

   localparam int NUM_BTN = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      GRANT = ST_GRANT
   } state_e;

   function automatic logic [1:0] onehot_to_idx(input logic [NUM_BTN-1:0] oh);
      case (oh)
         4'b0001: return 2'd0;
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // First set request at or after last+1, wrapping modulo NUM_BTN.
   function automatic logic [NUM_BTN-1:0] rr_pick(input logic [NUM_BTN-1:0] req,
                                                   input logic [1:0]         last);
      logic [NUM_BTN-1:0] sel;
      logic [1:0]         j;
      sel = {NUM_BTN{1'b0}};
      for (int k = 1; k <= NUM_BTN; k++) begin
         j = last + 2'(k);
         if (req[j] && (sel == {NUM_BTN{1'b0}})) begin
            sel[j] = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer followed by a stability counter.
// Emits a single-cycle pulse when the debounced level goes 0->1.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             meta_r;
   logic             sync_r;
   logic             level_r;
   logic             rise_r;
   logic [CNT_W-1:0] cnt_r;

   // Two-stage synchronizer for the asynchronous button input.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= btn;
         sync_r <= meta_r;
      end
   end

   // Level changes only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         rise_r  <= 1'b0;
      end else if (sync_r == level_r) begin
         cnt_r  <= {CNT_W{1'b0}};
         rise_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         level_r <= ~level_r;
         cnt_r   <= {CNT_W{1'b0}};
         rise_r  <= ~level_r;
      end else begin
         cnt_r  <= cnt_r + CNT_ONE;
         rise_r <= 1'b0;
      end
   end

   assign rise = rise_r;

endmodule

// File: rtl/btn_rr_arbiter.sv
// Four debounced push-buttons arbitrated round-robin into a valid/ready grant.
// Define BTN_RR_ENCODE_EN to drive idx with the binary index of the grant.
module btn_rr_arbiter
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTN-1:0]  btn,
   input  logic                ready,
   output logic                valid,
   output logic [NUM_BTN-1:0]  grant,
   output logic [1:0]          idx
);

   logic [NUM_BTN-1:0] rise_s;
   logic [NUM_BTN-1:0] clear_s;
   logic [NUM_BTN-1:0] pending_next_s;
   logic [NUM_BTN-1:0] grant_next_s;
   logic [1:0]         last_next_s;
   logic               valid_next_s;
   logic               accept_s;
   state_e             state_next_s;

   state_e             state_r;
   logic [NUM_BTN-1:0] pending_r;
   logic [NUM_BTN-1:0] grant_r;
   logic [1:0]         last_r;
   logic               valid_r;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .clk   (clk),
         .reset (reset),
         .btn   (btn[i]),
         .rise  (rise_s[i])
      );
   end

   assign accept_s = valid_r & ready;

   // A press landing on the granted button in the accept cycle stays pending.
   always_comb begin
      clear_s        = accept_s ? grant_r : {NUM_BTN{1'b0}};
      pending_next_s = (pending_r & ~clear_s) | rise_s;
   end

   // Grant FSM: grant is chosen on entry to GRANT and frozen until accepted.
   always_comb begin
      state_next_s = state_r;
      grant_next_s = grant_r;
      valid_next_s = valid_r;
      last_next_s  = last_r;
      case (state_r)
         IDLE: begin
            if (pending_r != {NUM_BTN{1'b0}}) begin
               state_next_s = GRANT;
               grant_next_s = rr_pick(pending_r, last_r);
               valid_next_s = 1'b1;
            end else begin
               state_next_s = IDLE;
               grant_next_s = {NUM_BTN{1'b0}};
               valid_next_s = 1'b0;
            end
         end
         GRANT: begin
            if (accept_s) begin
               state_next_s = IDLE;
               grant_next_s = {NUM_BTN{1'b0}};
               valid_next_s = 1'b0;
               last_next_s  = onehot_to_idx(grant_r);
            end else begin
               state_next_s = GRANT;
            end
         end
         default: begin
            state_next_s = IDLE;
            grant_next_s = {NUM_BTN{1'b0}};
            valid_next_s = 1'b0;
         end
      endcase
   end

   // Arbiter state; last resets to 3 so button 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         pending_r <= {NUM_BTN{1'b0}};
         grant_r   <= {NUM_BTN{1'b0}};
         valid_r   <= 1'b0;
         last_r    <= 2'd3;
      end else begin
         state_r   <= state_next_s;
         pending_r <= pending_next_s;
         grant_r   <= grant_next_s;
         valid_r   <= valid_next_s;
         last_r    <= last_next_s;
      end
   end

   assign valid = valid_r;
   assign grant = grant_r;

`ifdef BTN_RR_ENCODE_EN
   logic [1:0] idx_r;

   // Encoded index registered alongside the grant it describes.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_r <= 2'd0;
      end else begin
         idx_r <= onehot_to_idx(grant_next_s);
      end
   end

   assign idx = idx_r;
`else
   assign idx = 2'b00;
`endif

endmodule

// File: tb/tb_btn_rr_arbiter.sv
// Directed bench for btn_rr_arbiter with a short debounce window.
module tb_btn_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] btn;
   logic       ready;
   logic       valid;
   logic [3:0] grant;
   logic [1:0] idx;

   int n_cmp = 0;
   int n_err = 0;

   logic       tv [64];
   logic [3:0] tg [64];
   logic [1:0] ti [64];

`ifdef BTN_RR_ENCODE_EN
   localparam bit ENC_EN = 1'b1;
`else
   localparam bit ENC_EN = 1'b0;
`endif

   btn_rr_arbiter #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .ready (ready),
      .valid (valid),
      .grant (grant),
      .idx   (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] exp_idx(input logic [3:0] g);
      logic [1:0] e;
      case (g)
         4'b0001: e = 2'd0;
         4'b0010: e = 2'd1;
         4'b0100: e = 2'd2;
         4'b1000: e = 2'd3;
         default: e = 2'd0;
      endcase
      return ENC_EN ? e : 2'b00;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (valid) found = 1'b1;
      end
   endtask

   task automatic settle();
      btn = 4'b0000;
      repeat (12) @(negedge clk);
   endtask

   // Record 40 cycles, then check ngr back-to-back grants (nibble k of seq).
   task automatic run_seq(input string tag, input int ngr, input logic [15:0] seq);
      int t0;
      logic [3:0] eg;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         tv[i] = valid;
         tg[i] = grant;
         ti[i] = idx;
      end
      t0 = -1;
      for (int i = 39; i >= 0; i--) begin
         if (tv[i]) t0 = i;
      end
      if (t0 < 0 || t0 + 2 * ngr >= 40) begin
         check_eq({tag, "_found"}, 32'd0, 32'd1);
      end else begin
         for (int k = 0; k < ngr; k++) begin
            eg = seq[4*k +: 4];
            check_eq($sformatf("%s_v%0d", tag, k), 32'(tv[t0 + 2*k]), 32'd1);
            check_eq($sformatf("%s_g%0d", tag, k), 32'(tg[t0 + 2*k]), 32'(eg));
            check_eq($sformatf("%s_i%0d", tag, k), 32'(ti[t0 + 2*k]), 32'(exp_idx(eg)));
            check_eq($sformatf("%s_gap%0d", tag, k), 32'(tv[t0 + 2*k + 1]), 32'd0);
         end
      end
   endtask

   initial begin
      bit found;
      bit flag;

      reset = 1'b1;
      btn   = 4'b0000;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_idx", 32'(idx), 32'd0);
      reset = 1'b0;

      // Bounce shorter than the debounce window must never produce a grant.
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         btn = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
         @(negedge clk);
         if (valid) flag = 1'b1;
      end
      check_eq("bounce_no_valid", 32'(flag), 32'd0);
      btn = 4'b0001;
      wait_valid(20, found);
      check_eq("bounce_found", 32'(found), 32'd1);
      check_eq("bounce_grant", 32'(grant), 32'b0001);
      check_eq("bounce_idx", 32'(idx), 32'(exp_idx(4'b0001)));
      ready = 1'b1;
      @(negedge clk);
      check_eq("bounce_accept", 32'(valid), 32'd0);
      settle();

      // All four pressed together from a fresh reset.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      btn   = 4'b1111;
      run_seq("all4", 4, 16'h8421);
      check_eq("all4_empty", 32'(valid), 32'd0);
      settle();

      // Make last=0, then 0 and 2 together: 2 wins first.
      btn = 4'b0001;
      run_seq("last0", 1, 16'h0001);
      settle();
      btn = 4'b0101;
      run_seq("rr02", 2, 16'h0014);
      settle();

      // Grant held under backpressure while another button arrives.
      ready = 1'b0;
      btn   = 4'b0001;
      wait_valid(20, found);
      check_eq("hold_found", 32'(found), 32'd1);
      check_eq("hold_grant0", 32'(grant), 32'b0001);
      btn  = 4'b1001;
      flag = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!valid || grant !== 4'b0001) flag = 1'b1;
      end
      check_eq("hold_stable", 32'(flag), 32'd0);
      ready = 1'b1;
      @(negedge clk);
      check_eq("hold_accept", 32'(valid), 32'd0);
      wait_valid(4, found);
      check_eq("hold_next_found", 32'(found), 32'd1);
      check_eq("hold_next_grant", 32'(grant), 32'b1000);
      check_eq("hold_next_idx", 32'(idx), 32'(exp_idx(4'b1000)));
      @(negedge clk);
      check_eq("hold_next_accept", 32'(valid), 32'd0);
      settle();

      // Reset in the middle of a grant discards it and all pending requests.
      ready = 1'b0;
      btn   = 4'b0110;
      wait_valid(20, found);
      check_eq("mid_found", 32'(found), 32'd1);
      check_eq("mid_grant", 32'(grant), 32'b0010);
      reset = 1'b1;
      btn   = 4'b0000;
      @(negedge clk);
      check_eq("mid_rst_valid", 32'(valid), 32'd0);
      check_eq("mid_rst_grant", 32'(grant), 32'd0);
      check_eq("mid_rst_idx", 32'(idx), 32'd0);
      reset = 1'b0;
      flag  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (valid) flag = 1'b1;
      end
      check_eq("mid_no_pending", 32'(flag), 32'd0);
      ready = 1'b1;
      btn   = 4'b1111;
      run_seq("post_rst", 4, 16'h8421);
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
